// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 4-digit 7-segment display driver for the snake score
// display. The block owns the scan: it drives the 2-bit digit Select into an
// external combinational 4-way digit multiplexer and reads back that mux's
// 5-bit digit code on Bin_Out. The code is decoded to active-low segments.
// One active-low anode is lit per slot. A dead-time blank at the start of each
// slot keeps the previous digit's segments from ghosting onto the next anode.
//
// Slot timing (PreCnt counts 0..PRESCALE-1 per slot):
//   PreCnt <  DEADTIME   BLANK : all anodes off
//   PreCnt == DEADTIME-1       : Bin_Out decoded and captured into SegN
//   PreCnt >= DEADTIME   SHOW  : anode for the current Select lit
// The segments are captured on the same edge that lights the anode. The first
// SHOW cycle therefore already carries the right segments. SegN never changes
// while an anode is lit.
//
// Parameters:
//   PRESCALE  clock cycles per digit slot, legal 4..2^20
//   DEADTIME  blank cycles at the start of each slot, 1 <= DEADTIME < PRESCALE-1
//
// Ports:
//   Clk      in   1  system clock
//   Reset    in   1  asynchronous, active-high reset
//   Enable   in   1  1 = scan runs; 0 = display dark, scan frozen
//   Bin_Out  in   5  digit code from the external mux for the current Select
//   DpSel    in   2  digit that carries the decimal point (DP_EN builds only)
//   Select   out  2  digit select: 00 deci, 01 unit, 10 dec, 11 thousand
//   AnodeN   out  4  active-low one-hot anode, bit i lit when Select == i
//   SegN     out  7  active-low segments {g,f,e,d,c,b,a}
//   DpN      out  1  active-low decimal point
//
// Configuration macro:
//   DP_EN  when defined, adds DpSel. DpN is then captured together with SegN and
//          is low in the slot whose Select equals DpSel. When undefined, DpN is
//          tied high.
//
// All outputs come straight from flops. Bin_Out has no combinational path to
// any output.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [4:0] Bin_Out,
`ifdef DP_EN
  input  logic [1:0] DpSel,
`endif
  output logic [1:0] Select,
  output logic [3:0] AnodeN,
  output logic [6:0] SegN,
  output logic       DpN
);

  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW    = CNT_W'(DEADTIME);
  // Capture happens one cycle before SHOW, so the mux has had DEADTIME cycles
  // to settle after the Select change.
  localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_e;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // ---------------------------------------------------------------------------
  // Digit decode, active-low {g,f,e,d,c,b,a}.
  // Codes 0..15 are hex digits and 5'b10001 is a dash. Every other code with
  // bit 4 set is blank.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:     seg = 7'b1000000;
      5'd1:     seg = 7'b1111001;
      5'd2:     seg = 7'b0100100;
      5'd3:     seg = 7'b0110000;
      5'd4:     seg = 7'b0011001;
      5'd5:     seg = 7'b0010010;
      5'd6:     seg = 7'b0000010;
      5'd7:     seg = 7'b1111000;
      5'd8:     seg = 7'b0000000;
      5'd9:     seg = 7'b0010000;
      5'd10:    seg = 7'b0001000;  // A
      5'd11:    seg = 7'b0000011;  // b
      5'd12:    seg = 7'b1000110;  // C
      5'd13:    seg = 7'b0100001;  // d
      5'd14:    seg = 7'b0000110;  // E
      5'd15:    seg = 7'b0001110;  // F
      5'b10001: seg = 7'b0111111;  // dash
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       select_q,  select_d;
  logic [3:0]       anode_n_q, anode_n_d;
  logic [6:0]       seg_n_q,   seg_n_d;
  logic             capture;
  phase_e           phase_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // AnodeN is computed from the *next* PreCnt/Select. The registered anode
  // therefore lines up with the registered counter: it is dark for
  // PreCnt < DEADTIME and lit for PreCnt >= DEADTIME.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; otherwise a path
    // that skips the assignment would infer a latch.
    pre_cnt_d = pre_cnt_q;
    select_d  = select_q;
    anode_n_d = ANODE_OFF;
    seg_n_d   = seg_n_q;
    capture   = 1'b0;
    phase_d   = PH_BLANK;

    if (Enable) begin
      capture = (pre_cnt_q == CNT_CAPTURE);

      if (pre_cnt_q == CNT_LAST) begin
        pre_cnt_d = '0;
        select_d  = select_q + 2'd1;  // wraps 11 -> 00
      end else begin
        pre_cnt_d = pre_cnt_q + CNT_W'(1);
      end

      phase_d = (pre_cnt_d >= CNT_SHOW) ? PH_SHOW : PH_BLANK;

      if (phase_d == PH_SHOW) begin
        anode_n_d = ~(4'b0001 << select_d);
      end

      if (capture) begin
        seg_n_d = seg_decode(Bin_Out);
      end
    end
    // When disabled, the counter and Select hold, anodes go dark and SegN holds.
    // Re-enabling resumes from the held count, so a SHOW phase relights at once
    // with the held segments.
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_cnt_q <= '0;
      select_q  <= 2'b00;
      anode_n_q <= ANODE_OFF;
      seg_n_q   <= SEG_BLANK;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      select_q  <= select_d;
      anode_n_q <= anode_n_d;
      seg_n_q   <= seg_n_d;
    end
  end

  assign Select = select_q;
  assign AnodeN = anode_n_q;
  assign SegN   = seg_n_q;

  // ---------------------------------------------------------------------------
  // Decimal point
  // ---------------------------------------------------------------------------
`ifdef DP_EN
  logic dp_n_q, dp_n_d;

  // The point is captured with the segments. It therefore follows the same
  // no-change-while-lit rule.
  always_comb begin
    dp_n_d = dp_n_q;
    if (capture) begin
      dp_n_d = (select_q == DpSel) ? 1'b0 : 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dp_n_q <= 1'b1;
    end else begin
      dp_n_q <= dp_n_d;
    end
  end

  assign DpN = dp_n_q;
`else
  assign DpN = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Bench for seg_scan_driver with PRESCALE=8 and DEADTIME=2.
// A table of slot records {code, expected Select, expected segments} drives a
// sequence of full scan slots. Hand-written sequences then cover the
// multi-cycle corner cases:
//   - Enable dropped in SHOW and resumed.
//   - Enable dropped in BLANK across the capture point.
//   - Asynchronous reset in the middle of a slot.
// A small cycle model tracks the expected count, Select, anode, segments and
// decimal point. Its segment values come only from the hand-computed table
// entries.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int PRESCALE = 8;
  localparam int DEADTIME = 2;

  logic       Clk;
  logic       Reset;
  logic       Enable;
  logic [4:0] Bin_Out;
  logic [1:0] Select;
  logic [3:0] AnodeN;
  logic [6:0] SegN;
  logic       DpN;
`ifdef DP_EN
  logic [1:0] DpSel;
`endif

  seg_scan_driver #(
    .PRESCALE (PRESCALE),
    .DEADTIME (DEADTIME)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .Bin_Out (Bin_Out),
`ifdef DP_EN
    .DpSel   (DpSel),
`endif
    .Select  (Select),
    .AnodeN  (AnodeN),
    .SegN    (SegN),
    .DpN     (DpN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Expected-state model
  // ---------------------------------------------------------------------------
  logic [2:0] m_pre;
  logic [1:0] m_sel;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [6:0] cur_seg_exp;  // hand-computed segments for the code on Bin_Out

  task automatic model_reset();
    m_pre = 3'd0;
    m_sel = 2'd0;
    m_an  = 4'b1111;
    m_seg = 7'b1111111;
    m_dp  = 1'b1;
  endtask

  // One clock: wait for the active edge, advance the model, then settle on the
  // falling edge where outputs are sampled and inputs are changed.
  task automatic tick();
    logic [2:0] p;
    logic [1:0] s;
    p = m_pre;
    s = m_sel;
    @(posedge Clk);
    if (Enable) begin
      if (p == 3'(DEADTIME - 1)) begin
        m_seg = cur_seg_exp;
`ifdef DP_EN
        m_dp = (s == DpSel) ? 1'b0 : 1'b1;
`endif
      end
      if (p == 3'(PRESCALE - 1)) begin
        m_pre = 3'd0;
        m_sel = s + 2'd1;
      end else begin
        m_pre = p + 3'd1;
      end
      m_an = (m_pre < 3'(DEADTIME)) ? 4'b1111 : ~(4'b0001 << m_sel);
    end else begin
      m_an = 4'b1111;
    end
    @(negedge Clk);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " Select"}, 8'(Select), 8'(m_sel));
    check({tag, " AnodeN"}, 8'(AnodeN), 8'(m_an));
    check({tag, " SegN"},   8'(SegN),   8'(m_seg));
    check({tag, " DpN"},    8'(DpN),    8'(m_dp));
  endtask

  // ---------------------------------------------------------------------------
  // Slot vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] code;
    logic [1:0] sel;   // Select expected for this slot
    logic [6:0] seg;   // SegN expected in this slot's SHOW phase
  } slot_vec_t;

  localparam int NVEC = 22;
  slot_vec_t vecs[NVEC];

  initial begin
    // Fixed 5 across a full Select wrap.
    vecs[0]  = '{5'd5,     2'd0, 7'b0010010};
    vecs[1]  = '{5'd5,     2'd1, 7'b0010010};
    vecs[2]  = '{5'd5,     2'd2, 7'b0010010};
    vecs[3]  = '{5'd5,     2'd3, 7'b0010010};
    // Per-digit codes 3,1,4,F.
    vecs[4]  = '{5'd3,     2'd0, 7'b0110000};
    vecs[5]  = '{5'd1,     2'd1, 7'b1111001};
    vecs[6]  = '{5'd4,     2'd2, 7'b0011001};
    vecs[7]  = '{5'd15,    2'd3, 7'b0001110};
    // Codes with bit 4 set.
    vecs[8]  = '{5'b10000, 2'd0, 7'b1111111};
    vecs[9]  = '{5'b10001, 2'd1, 7'b0111111};
    vecs[10] = '{5'b11111, 2'd2, 7'b1111111};
    // Remaining digits.
    vecs[11] = '{5'd0,     2'd3, 7'b1000000};
    vecs[12] = '{5'd8,     2'd0, 7'b0000000};
    vecs[13] = '{5'd10,    2'd1, 7'b0001000};
    vecs[14] = '{5'd11,    2'd2, 7'b0000011};
    vecs[15] = '{5'd12,    2'd3, 7'b1000110};
    vecs[16] = '{5'd13,    2'd0, 7'b0100001};
    vecs[17] = '{5'd14,    2'd1, 7'b0000110};
    vecs[18] = '{5'd2,     2'd2, 7'b0100100};
    vecs[19] = '{5'd6,     2'd3, 7'b0000010};
    vecs[20] = '{5'd7,     2'd0, 7'b1111000};
    vecs[21] = '{5'd9,     2'd1, 7'b0010000};
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset       = 1'b1;
    Enable      = 1'b0;
    Bin_Out     = 5'd0;
    cur_seg_exp = 7'b1111111;
`ifdef DP_EN
    DpSel       = 2'b01;
`endif
    model_reset();

    // Reset values.
    #3;
    check("reset Select", 8'(Select), 8'h00);
    check("reset AnodeN", 8'(AnodeN), 8'h0f);
    check("reset SegN",   8'(SegN),   8'h7f);
    check("reset DpN",    8'(DpN),    8'h01);

    @(negedge Clk);
    @(negedge Clk);
    Reset  = 1'b0;
    Enable = 1'b1;

    // Table-driven full slots.
    for (int i = 0; i < NVEC; i++) begin
      Bin_Out     = vecs[i].code;
      cur_seg_exp = vecs[i].seg;
      check($sformatf("slot%0d start Select", i), 8'(Select), 8'(vecs[i].sel));
      for (int c = 0; c < PRESCALE; c++) begin
        tick();
        check_outputs($sformatf("slot%0d cyc%0d", i, c));
        if (c >= DEADTIME - 1 && c < PRESCALE - 1) begin
          check($sformatf("slot%0d cyc%0d show SegN", i, c), 8'(SegN), 8'(vecs[i].seg));
        end
      end
    end

    // Enable dropped in SHOW at PreCnt=5 (Select=10), then resumed.
    Bin_Out     = 5'd5;
    cur_seg_exp = 7'b0010010;
    for (int c = 0; c < 5; c++) tick();
    check("pre-hold AnodeN", 8'(AnodeN), 8'h0b);
    Enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outputs($sformatf("hold cyc%0d", c));
      check($sformatf("hold cyc%0d AnodeN dark", c), 8'(AnodeN), 8'h0f);
      check($sformatf("hold cyc%0d Select", c), 8'(Select), 8'h02);
    end
    Enable = 1'b1;
    tick();
    check("resume pre6 AnodeN", 8'(AnodeN), 8'h0b);
    check("resume pre6 SegN",   8'(SegN),   8'h12);
    tick();
    check("resume pre7 AnodeN", 8'(AnodeN), 8'h0b);
    check("resume pre7 Select", 8'(Select), 8'h02);
    tick();
    check("resume wrap Select", 8'(Select), 8'h03);
    check("resume wrap AnodeN", 8'(AnodeN), 8'h0f);

    // Enable dropped in BLANK at PreCnt=1: no capture while disabled.
    tick();
    Enable      = 1'b0;
    Bin_Out     = 5'd9;
    cur_seg_exp = 7'b0010000;
    tick();
    tick();
    check_outputs("blank hold");
    check("blank hold SegN kept", 8'(SegN), 8'h12);
    Enable = 1'b1;
    tick();
    check_outputs("blank resume");
    check("blank resume AnodeN", 8'(AnodeN), 8'h07);
    check("blank resume SegN",   8'(SegN),   8'h10);
    for (int c = 0; c < PRESCALE - 2; c++) begin
      tick();
      check_outputs($sformatf("blank finish cyc%0d", c));
    end

    // Asynchronous reset in the middle of a Select=10 SHOW phase.
    Bin_Out     = 5'd4;
    cur_seg_exp = 7'b0011001;
    for (int c = 0; c < 2 * PRESCALE + 4; c++) tick();
    check("pre-reset Select", 8'(Select), 8'h02);
    check("pre-reset AnodeN", 8'(AnodeN), 8'h0b);
    #2;
    Reset = 1'b1;
    #0.5;
    check("async reset Select", 8'(Select), 8'h00);
    check("async reset AnodeN", 8'(AnodeN), 8'h0f);
    check("async reset SegN",   8'(SegN),   8'h7f);
    check("async reset DpN",    8'(DpN),    8'h01);
    #0.5;
    Reset = 1'b0;
    model_reset();
    Bin_Out     = 5'd3;
    cur_seg_exp = 7'b0110000;
    tick();
    check_outputs("post-reset blank");
    check("post-reset blank AnodeN", 8'(AnodeN), 8'h0f);
    tick();
    check_outputs("post-reset show");
    check("post-reset show AnodeN", 8'(AnodeN), 8'h0e);
    check("post-reset show SegN",   8'(SegN),   8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed 4-digit 7-segment display driver for the snake score display. It owns the display scan. It generates the 2-bit digit Select that steers the combinational 4-way digit multiplexer, and takes back that multiplexer's 5-bit digit code. It decodes the code to segments and drives one-hot anodes, with a dead-time blank between digits to prevent ghosting.

Parameters:
PRESCALE, 50000, clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..2^20.
DEADTIME, 16, cycles at the start of each slot with all anodes off; must be < PRESCALE-1.

Ports:
Clk  input  1  system clock.
Reset  input  1  asynchronous, active-high reset.
Enable  input  1  1 = scan runs; 0 = display dark, scan frozen.
Bin_Out  input  5  digit code from the 4-way mux, valid combinationally for the current Select.
Select  output  2  digit select to the mux: 00 deci, 01 unit, 10 dec, 11 thousand.
AnodeN  output  4  active-low one-hot anode; bit i lit when Select==i.
SegN  output  7  active-low segments, order {g,f,e,d,c,b,a}.
DpN  output  1  active-low decimal point (only meaningful under DP_EN).

Behaviour:
- Reset (async, active-high): PreCnt=0, Select=2'b00, AnodeN=4'b1111, SegN=7'b1111111, DpN=1. All outputs registered.
- PreCnt counts 0..PRESCALE-1 while Enable=1. At PreCnt==PRESCALE-1: PreCnt->0 and Select->Select+1, wrapping 11->00.
- Slot phases, derived from PreCnt:
  - BLANK while PreCnt<DEADTIME: AnodeN=1111.
  - SHOW while PreCnt>=DEADTIME: AnodeN = ~(1<<Select).
- SegN capture: on the cycle PreCnt==DEADTIME-1, register decode(Bin_Out). This is at least DEADTIME cycles after the Select change, so mux settling is guaranteed. SegN holds until the next capture.
- Consequence: the first SHOW cycle shows the correct segments and anode together. SegN never changes while any anode is lit.
- Decode (5-bit code):
  - 0..9 give standard digits; 1 lights b,c only; 7 lights a,b,c.
  - 10..15 give hex A,b,C,d,E,F.
  - 5'b10001 gives dash (g only).
  - 5'b10000 and all other codes with bit4=1 give blank (1111111).
- Enable=0: PreCnt and Select hold; AnodeN=1111 on the next edge; SegN holds.
- Enable 0->1: resumes from the held PreCnt. If PreCnt>=DEADTIME, anodes relight immediately with the held SegN.
- Reset asserted mid-slot: immediate return to reset values. First post-reset slot is Select=00 with a full BLANK phase.
- No combinational path from Bin_Out to any output.

Optional Feature:
DP_EN. When defined:
- Adds input DpSel[1:0].
- DpN is captured with SegN at PreCnt==DEADTIME-1: DpN=0 if Select==DpSel, else 1.
- Default wiring DpSel=2'b01 puts the point after the units digit, before deci.

When not defined:
- No DpSel port.
- DpN tied to 1 (point off).

Test Plan:
1. Reset then run with PRESCALE=8, DEADTIME=2, Enable=1, Bin_Out fixed at 5 -> Select changes every 8 cycles: 00,01,10,11,00. AnodeN=1111 for 2 cycles per slot, then 1110/1101/1011/0111. SegN=7'b0010010.
2. Bin_Out driven per Select as 3,1,4,15 -> in the SHOW phase, SegN is 0110000, 1111001, 0011001, 0001110 respectively. SegN never toggles while an AnodeN bit is 0.
3. Codes 5'b10000, 5'b10001, 5'b11111 -> SegN 1111111, 0111111, 1111111.
4. Enable drops mid-SHOW at PreCnt=5 -> AnodeN=1111 the next cycle, Select/PreCnt frozen. Re-enable -> PreCnt continues 5,6,7, anodes lit, then Select advances.
5. Reset pulsed for 1 ns mid-slot (Select=10) -> asynchronous immediate return to Select=00, AnodeN=1111, SegN=1111111. Restart begins with a BLANK phase.
6. DP_EN defined, DpSel=01 -> DpN=0 only while AnodeN=1101; DpN=1 in all other slots. Without DP_EN, DpN=1 always.
